// File: rtl/extend_pipe.sv
// Registered immediate extender: decodes the instruction immediate field and
// delivers results through a 2-entry in-order buffer with valid/ready and flush.
module extend_pipe #(
  parameter int DATA_W   = 32,
  parameter int INSTR_W  = 24,
  parameter int BR_SHIFT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] Instr,
  input  logic [2:0]         ImmSrc,
  input  logic               InValid,
  output logic               InReady,
  input  logic               Flush,
  input  logic               OutReady,
  output logic               OutValid,
  output logic [DATA_W-1:0]  ExtImm,
  output logic               Err
);

  localparam int ENTRY_W = DATA_W + 1;

  // ---------------------------------------------------------------------------
  // Immediate decode (input side, purely combinational)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0]  ext_value;
  logic               ext_err;
  logic [31:0]        rot_src;
  logic [4:0]         rot_amt;
  logic [31:0]        rot_value;
  logic [DATA_W-1:0]  br_sext;
  logic [DATA_W-1:0]  br_value;
  logic [ENTRY_W-1:0] new_entry;

  assign rot_src   = {24'd0, Instr[7:0]};
  assign rot_amt   = {Instr[11:8], 1'b0};
  // A shift by 32 yields zero, so a zero rotate amount falls out naturally.
  assign rot_value = (rot_src >> rot_amt) | (rot_src << (6'd32 - {1'b0, rot_amt}));
  assign br_sext   = DATA_W'($signed(Instr));
  assign br_value  = br_sext << BR_SHIFT;

  always_comb begin
    ext_value = '0;
    ext_err   = 1'b0;
    case (ImmSrc)
      3'b000:  ext_value = DATA_W'(Instr[7:0]);
      3'b001:  ext_value = DATA_W'(Instr[11:0]);
      3'b010:  ext_value = br_value;
      3'b011:  ext_value = DATA_W'(rot_value);
      3'b100:  ext_value = DATA_W'($signed(Instr[11:0]));
      3'b101:  ext_value = DATA_W'({Instr[11:8], Instr[3:0]});
      default: ext_err   = 1'b1;
    endcase
  end

  assign new_entry = {ext_err, ext_value};

  // ---------------------------------------------------------------------------
  // Buffer state
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem_reg [2];
  logic               head_reg, head_next;
  logic               tail_reg, tail_next;
  logic [1:0]         count_reg, count_next;
  logic               in_ready_reg, in_ready_next;
  logic               out_valid_reg, out_valid_next;
  logic [ENTRY_W-1:0] out_reg, out_next;
  logic               push;
  logic               pop;

  assign push = InValid & in_ready_reg & ~Flush;
  assign pop  = out_valid_reg & OutReady & ~Flush;

  always_comb begin
    count_next = count_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    out_next   = out_reg;
    if (Flush) begin
      count_next = 2'd0;
      head_next  = 1'b0;
      tail_next  = 1'b0;
    end else begin
      count_next = count_reg + {1'b0, push} - {1'b0, pop};
      head_next  = head_reg ^ pop;
      tail_next  = tail_reg ^ push;
      // The output register always mirrors the post-edge head entry; when that
      // head is the entry being written this cycle, bypass the storage array.
      if (count_next != 2'd0) begin
        if (push && (tail_reg == head_next)) begin
          out_next = new_entry;
        end else begin
          out_next = mem_reg[head_next];
        end
      end
    end
    in_ready_next  = (count_next != 2'd2);
    out_valid_next = (count_next != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg      <= 1'b0;
      tail_reg      <= 1'b0;
      count_reg     <= 2'd0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
    end else begin
      head_reg      <= head_next;
      tail_reg      <= tail_next;
      count_reg     <= count_next;
      in_ready_reg  <= in_ready_next;
      out_valid_reg <= out_valid_next;
      out_reg       <= out_next;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (reset) begin
          mem_reg[gi] <= '0;
        end else if (push && (tail_reg == 1'(gi))) begin
          mem_reg[gi] <= new_entry;
        end
      end
    end
  endgenerate

  assign InReady  = in_ready_reg;
  assign OutValid = out_valid_reg;
  assign ExtImm   = out_reg[DATA_W-1:0];
  assign Err      = out_reg[DATA_W];

endmodule
